// File: rtl/tick_dispatch_pkg.sv
// Shared definitions for the tick dispatcher: FSM state encoding and
// default parameter values.
package tick_dispatch_pkg;

    localparam int MAX_PEND_DEF = 3;
    localparam int TMO_DEF      = 16;
    localparam int CNT_W_DEF    = 16;
    localparam int PEND_W       = 3;
    localparam int WAIT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_ERR  = 2'd3
    } tick_state_e;

endpackage

// File: rtl/tick_pend_cnt.sv
// Saturating count of buffered ticks with a sticky overflow flag.
// load has priority over inc/dec; a simultaneous inc and dec cancel out.
module tick_pend_cnt
    import tick_dispatch_pkg::*;
#(
    parameter int MAX_PEND = MAX_PEND_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    input  logic              load,
    input  logic [PEND_W-1:0] load_val,
    output logic [PEND_W-1:0] count,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(MAX_PEND);

    logic [PEND_W-1:0] count_q, count_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (load) begin
            count_d = load_val;
        end else if (inc && !dec) begin
            // A tick arriving when full with no dispatch to free a slot is lost.
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/tick_dispatch.sv
// Buffers upstream ticks and dispatches each one as a req/ack handshake,
// with a bounded wait, a one-cycle gap between requests and error recovery.
module tick_dispatch
    import tick_dispatch_pkg::*;
#(
    parameter int MAX_PEND = MAX_PEND_DEF,
    parameter int TMO      = TMO_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             ack_i,
    output logic             req_o,
    output logic             busy_o,
    output logic [2:0]       pend_o,
    output logic [CNT_W-1:0] done_o,
    output logic             ovf_o,
    output logic             tmo_o
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_GAP  = ST_GAP;
    localparam logic [1:0] S_ERR  = ST_ERR;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TMO - 1);

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  done_q, done_d;
    logic              tmo_q, tmo_d;

    logic              start;
    logic              pend_load;
    logic [PEND_W-1:0] pend_cnt;
    logic              pend_ovf;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        start     = 1'b0;
        pend_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_cnt != '0) begin
                    state_d = S_REQ;
                    start   = 1'b1;
                    wait_d  = '0;
                end
            end
            S_REQ: begin
                // An ack on the last permitted cycle still counts as success.
                if (ack_i) begin
                    state_d = S_GAP;
                    done_d  = done_q + CNT_W'(1);
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                // Recovery flushes the backlog; only a tick on this edge survives.
                state_d   = S_IDLE;
                pend_load = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            wait_q  <= '0;
            done_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    tick_pend_cnt #(
        .MAX_PEND (MAX_PEND)
    ) u_pend (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (tick_i),
        .dec      (start),
        .load     (pend_load),
        .load_val ({2'b00, tick_i}),
        .count    (pend_cnt),
        .ovf      (pend_ovf)
    );

    assign req_o  = req_q;
    assign busy_o = (state_q != S_IDLE) || (pend_cnt != '0);
    assign pend_o = pend_cnt;
    assign done_o = done_q;
    assign ovf_o  = pend_ovf;
    assign tmo_o  = tmo_q;

endmodule

// File: tb/tb_tick_dispatch.sv
// Directed and randomized checks of tick_dispatch against a cycle-level
// behavioural model of the dispatch rules.
module tb_tick_dispatch;

    localparam int MAX_PEND = 3;
    localparam int TMO      = 16;
    localparam int CNT_W    = 4;
    localparam int CNT_MOD  = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic             tick_i;
    logic             ack_i;
    logic             req_o;
    logic             busy_o;
    logic [2:0]       pend_o;
    logic [CNT_W-1:0] done_o;
    logic             ovf_o;
    logic             tmo_o;

    int errors = 0;
    int checks = 0;

    // Model: phase 0=idle, 1=requesting, 2=gap, 3=error
    int m_ph;
    int m_pend;
    int m_wait;
    int m_done;
    bit m_ovf;
    bit m_tmo;

    tick_dispatch #(
        .MAX_PEND (MAX_PEND),
        .TMO      (TMO),
        .CNT_W    (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (tick_i),
        .ack_i  (ack_i),
        .req_o  (req_o),
        .busy_o (busy_o),
        .pend_o (pend_o),
        .done_o (done_o),
        .ovf_o  (ovf_o),
        .tmo_o  (tmo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph   = 0;
        m_pend = 0;
        m_wait = 0;
        m_done = 0;
        m_ovf  = 1'b0;
        m_tmo  = 1'b0;
    endtask

    task automatic model_step(input bit tk, input bit ak);
        bit start;
        bit err_exit;
        start    = 1'b0;
        err_exit = 1'b0;
        case (m_ph)
            0: if (m_pend > 0) begin
                start  = 1'b1;
                m_ph   = 1;
                m_wait = 0;
            end
            1: if (ak) begin
                m_ph   = 2;
                m_done = (m_done + 1) % CNT_MOD;
            end else if (m_wait == TMO - 1) begin
                m_ph  = 3;
                m_tmo = 1'b1;
            end else begin
                m_wait = m_wait + 1;
            end
            2: m_ph = 0;
            default: begin
                m_ph     = 0;
                err_exit = 1'b1;
            end
        endcase
        if (err_exit) begin
            m_pend = tk ? 1 : 0;
        end else if (tk && !start) begin
            if (m_pend == MAX_PEND) m_ovf = 1'b1;
            else m_pend = m_pend + 1;
        end else if (start && !tk) begin
            m_pend = m_pend - 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},  32'(req_o),  32'(m_ph == 1));
        chk({tag, ".busy"}, 32'(busy_o), 32'((m_ph != 0) || (m_pend != 0)));
        chk({tag, ".pend"}, 32'(pend_o), 32'(m_pend));
        chk({tag, ".done"}, 32'(done_o), 32'(m_done));
        chk({tag, ".ovf"},  32'(ovf_o),  32'(m_ovf));
        chk({tag, ".tmo"},  32'(tmo_o),  32'(m_tmo));
    endtask

    task automatic step(input string tag, input bit tk, input bit ak);
        tick_i = tk;
        ack_i  = ak;
        @(posedge clk);
        if (rst_n) model_step(tk, ak);
        #1;
        check_all(tag);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        step("rst", 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int req_cycles;
        bit mode;
        rst_n  = 1'b0;
        tick_i = 1'b0;
        ack_i  = 1'b0;
        model_reset();
        #2;
        check_all("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold");
        rst_n = 1'b1;
        idle_steps("post_rst", 3);

        // Single tick, ack on the third request cycle
        step("single", 1'b1, 1'b0);
        step("single", 1'b0, 1'b0);
        step("single", 1'b0, 1'b0);
        step("single", 1'b0, 1'b0);
        step("single", 1'b0, 1'b1);
        idle_steps("single", 3);
        chk("single.done_abs", 32'(done_o), 32'd1);

        // Four consecutive ticks with ack held high
        for (int i = 0; i < 4; i++) step("burst4", 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) step("burst4", 1'b0, 1'b1);
        chk("burst4.done_abs", 32'(done_o), 32'd5);
        chk("burst4.ovf_abs", 32'(ovf_o), 32'd0);

        // ack outside REQ must be ignored
        for (int i = 0; i < 3; i++) step("stray_ack", 1'b0, 1'b1);

        // Five ticks while stalled: saturate and overflow
        for (int i = 0; i < 5; i++) step("sat", 1'b1, 1'b0);
        chk("sat.pend_abs", 32'(pend_o), 32'd3);
        chk("sat.ovf_abs", 32'(ovf_o), 32'd1);
        for (int i = 0; i < 12; i++) step("sat_drain", 1'b0, 1'b1);

        // Timeout: no ack, then a tick on the error exit edge
        pulse_reset();
        step("tmo", 1'b1, 1'b0);
        req_cycles = 0;
        for (int i = 0; i < 17; i++) begin
            step("tmo", 1'b0, 1'b0);
            if (req_o) req_cycles++;
        end
        chk("tmo.req_width", 32'(req_cycles), 32'(TMO));
        step("tmo_exit", 1'b1, 1'b0);
        chk("tmo.pend_reload", 32'(pend_o), 32'd1);
        chk("tmo.flag_abs", 32'(tmo_o), 32'd1);
        for (int i = 0; i < 4; i++) step("tmo_recover", 1'b0, 1'b1);

        // Asynchronous reset mid-request with two ticks buffered
        pulse_reset();
        for (int i = 0; i < 3; i++) step("midrst_setup", 1'b1, 1'b0);
        chk("midrst.pend_before", 32'(pend_o), 32'd2);
        chk("midrst.req_before", 32'(req_o), 32'd1);
        tick_i = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst.req", 32'(req_o), 32'd0);
        chk("midrst.pend", 32'(pend_o), 32'd0);
        chk("midrst.busy", 32'(busy_o), 32'd0);
        chk("midrst.done", 32'(done_o), 32'd0);
        model_reset();
        step("midrst_hold", 1'b0, 1'b1);
        rst_n = 1'b1;
        idle_steps("midrst_after", 5);

        // Randomized traffic alternating between stalling and eager downstream
        for (int blk = 0; blk < 8; blk++) begin
            mode = blk[0];
            for (int i = 0; i < 120; i++) begin
                step("rand",
                     ($urandom_range(0, 2) == 0),
                     mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 40) == 0));
            end
        end

        // Drain with ack held high: block must go quiet
        for (int i = 0; i < 20; i++) step("drain", 1'b0, 1'b1);
        chk("drain.busy_abs", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_dispatch.md
TICK_DISPATCH -- requirements
Module: tick_dispatch

Interface
REQ-001 Parameter MAX_PEND, default 3: maximum number of buffered ticks awaiting dispatch (1..7).
REQ-002 Parameter TMO, default 16: cycles the block waits for ack_i while requesting, before declaring a timeout (2..255).
REQ-003 Parameter CNT_W, default 16: width of the completed-transaction counter.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 tick_i  input  1  one-cycle period pulse from the upstream delay stage (its sig output).
REQ-007 ack_i  input  1  downstream acknowledge; sampled only in state REQ.
REQ-008 req_o  output  1  request to downstream; registered, high exactly while state is REQ.
REQ-009 busy_o  output  1  high when state is not IDLE or pend_o is non-zero.
REQ-010 pend_o  output  3  number of buffered, undispatched ticks.
REQ-011 done_o  output  CNT_W  count of acknowledged transactions; wraps modulo 2^CNT_W.
REQ-012 ovf_o  output  1  sticky flag: a tick arrived while pend_o was MAX_PEND and no dispatch was starting.
REQ-013 tmo_o  output  1  sticky flag: a request timed out.

Function
REQ-014 FSM states are IDLE, REQ, GAP and ERR.
REQ-015 IDLE -> REQ when pend_o > 0; pend_o decrements on that edge; otherwise IDLE holds.
REQ-016 REQ -> GAP on a cycle with ack_i=1; done_o increments on the same edge.
REQ-017 REQ -> ERR when the wait counter reaches TMO-1 with ack_i=0; tmo_o sets on the same edge.
REQ-018 The wait counter clears on entry to REQ and increments once per REQ cycle; ack_i on the final (TMO-th) cycle wins over timeout.
REQ-019 GAP lasts exactly one cycle with req_o=0, then goes to IDLE; back-to-back requests are therefore separated by at least 2 low cycles.
REQ-020 ERR lasts exactly one cycle, then goes to IDLE; on the exit edge pend_o is loaded with 1 if tick_i=1, else 0, so all earlier buffered ticks are discarded.
REQ-021 In all states other than ERR exit, a tick increments pend_o, saturating at MAX_PEND.
REQ-022 A tick and a dispatch start on the same edge leave pend_o unchanged, and do not set ovf_o.
REQ-023 A tick at saturation with no dispatch start on that edge is dropped and sets ovf_o.
REQ-024 ack_i outside REQ is ignored and has no effect on any output.
REQ-025 Latency: with the block idle and pend_o=0, a tick at edge t gives pend_o=1 after t and req_o=1 after t+1.
REQ-026 ovf_o and tmo_o clear only on reset.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force: state IDLE, req_o=0, pend_o=0, wait counter 0, done_o=0, ovf_o=0, tmo_o=0, busy_o=0.
REQ-028 Reset deassertion SHALL be synchronised by the integrator.
REQ-029 The first functional edge is the first posedge clk with rst_n=1.
REQ-030 Reset asserted mid-REQ SHALL drop req_o immediately and not count a transaction.

Structure
REQ-031 A shared package tick_dispatch_pkg SHALL hold the state enum (IDLE, REQ, GAP, ERR) and the default values of MAX_PEND, TMO and CNT_W.
REQ-032 The saturating pending counter SHALL be a sub-module, tick_pend_cnt, with inputs inc, dec, load and load_val, and outputs count and ovf.
REQ-033 The top level holds the FSM, the wait counter and done_o; all outputs are registered except busy_o, which is combinational from registers only.

Verification
REQ-034 Single tick, ack on the 3rd REQ cycle: req_o high 3 cycles starting at t+2, done_o=1, pend_o=0, flags 0.
REQ-035 Four ticks on consecutive cycles, ack_i held high, MAX_PEND=3: ovf_o=0 (the first dispatch frees a slot), done_o=4, each req_o pulse exactly 1 cycle wide with 2-cycle gaps.
REQ-036 Five ticks on consecutive cycles while ack_i=0 stalls REQ: pend_o saturates at 3 and ovf_o sets on the 5th tick.
REQ-037 ack_i never asserted, TMO=16: req_o high exactly 16 cycles, then ERR for 1 cycle; tmo_o=1; pend_o=0 (or 1 if tick_i=1 on the ERR exit edge).
REQ-038 rst_n pulled low mid-REQ with pend_o=2: all outputs 0 before the next clk edge; after release the block remains idle until a new tick.
REQ-039 Formal checks: G(req_o -> F(!req_o)) under any ack_i; pend_o <= MAX_PEND always; and, once ticks stop, ack_i held high implies F G(!busy_o).
